ramsdp_pipe: RTL and testbench
==============================

Name: ramsdp_pipe

Overview:
Parametrised simple dual-port RAM, next generation of the team's single-clock SDP memory. Port A is read/write with byte write masks. Port B is read-only. Both ports have per-port enables, a selectable read latency (1 or 2 cycles) and a valid strobe. Read-during-write behaviour on both ports is selectable per instance. It is the standard behavioural buffer memory for FIFOs, caches and register files in the benchmark designs.

Parameters:
DW, 32, data width in bits; must be a multiple of BW
AW, 6, address width; depth = 2**AW words
BW, 8, bits per write-mask lane; lanes NB = DW/BW
RDLAT, 1, read latency in cycles from enable to data; legal values 1 or 2
WFIRST, 0, port A read-during-write: 0 = read-first (old data), 1 = write-first (merged new data)
BYPASS, 0, port B collision with a port A write to the same address in the same cycle: 0 = old data, 1 = merged new data

Ports:
clk  input  1  clock, all logic on rising edge
nreset  input  1  asynchronous active-low reset
en_a  input  1  port A access enable
we_a  input  1  port A write enable, qualified by en_a
wmask_a  input  DW/BW  per-lane write mask, 1 = write lane
addr_a  input  AW  port A address
din_a  input  DW  port A write data
dout_a  output  DW  port A read data
vld_a  output  1  dout_a valid strobe
en_b  input  1  port B read enable
addr_b  input  AW  port B address
dout_b  output  DW  port B read data
vld_b  output  1  dout_b valid strobe
busy  output  1  memory initialisation in progress; tied 0 without RAMSDP_INIT_EN

Behaviour:
- Reset (nreset low, asynchronous): dout_a, dout_b = 0; vld_a, vld_b = 0; all pipeline stages = 0. Memory contents are not reset, except under RAMSDP_INIT_EN.
- Write: on en_a & we_a, lane i of mem[addr_a] is replaced by din_a lane i where wmask_a[i] = 1. Other lanes are unchanged. All-zero mask means no write, but the read still occurs.
- Port A read: every en_a cycle reads addr_a, whether or not we_a is set.
  - WFIRST = 0: returns pre-write contents.
  - WFIRST = 1: returns {masked din_a lanes, unmasked old lanes}.
- Port B read: on en_b, reads addr_b.
  - On the same cycle as a port A write with addr_b == addr_a, BYPASS selects old (0) or merged new (1) data.
  - Different addresses never interact.
- Latency: data and vld appear RDLAT cycles after the enable edge.
  - RDLAT = 1: registered at edge N+1.
  - RDLAT = 2: one extra output register stage, valid at edge N+2.
  - vld_x pulses exactly one cycle per enabled access.
  - Back-to-back enables give one result per cycle, fully pipelined.
- Hold: when no valid result is presented, dout_x holds its last value. dout_x does not return to 0.
- Write with en_a = 0 is ignored. we_a without en_a has no effect.
- Reset mid-operation clears in-flight valids; data already written stays in memory.
- Elaboration check: DW % BW != 0 or RDLAT not in {1,2} causes $error.

Optional Feature:
Macro RAMSDP_INIT_EN.
- Defined:
  - After nreset deasserts, an AW-bit counter walks addresses 0..2**AW-1, writing 0, one word per cycle.
  - busy = 1 from reset release until the cycle after address 2**AW-1 is written. Total duration: 2**AW cycles.
  - While busy: en_a, en_b and we_a are ignored, and vld_a, vld_b stay 0.
  - Reset asserted mid-sweep restarts the sweep from 0 on release.
- Undefined: no counter, busy tied 0, memory contents undefined until written.

Test Plan:
- Full-word write then read (defaults): write addr 5 = 0xDEADBEEF, mask 4'hF; next cycle en_b addr 5 -> vld_b and dout_b = 0xDEADBEEF one cycle later.
- Byte mask: mem[3] = 0x11223344; write din 0xAABBCCDD with mask 4'b0101; read -> 0x11BB33DD.
- Collision, BYPASS = 0: mem[7] = 0x0; same-cycle port A write 0x12345678 and port B read of 7 -> dout_b = 0x0. With BYPASS = 1 -> 0x12345678. With WFIRST = 1, dout_a = 0x12345678.
- Latency/throughput, RDLAT = 2: en_b for 4 consecutive cycles, addresses 0..3 -> vld_b high for 4 consecutive cycles starting 2 edges after the first; data returned in order. dout_b holds the address 3 data afterwards.
- Reset mid-read: assert nreset low while vld_b is pending -> vld_b and dout_b = 0 immediately (asynchronous). Memory still holds prior writes after release.
- RAMSDP_INIT_EN, AW = 4: release reset -> busy high exactly 16 cycles; accesses during busy are ignored (no vld). Afterwards every address reads 0.

Source files
------------

// File: rtl/ramsdp_pipe.sv
// Simple dual-port RAM: port A read/write with byte lanes, port B read-only, 1 or 2 cycle read latency.
// Optional macro RAMSDP_INIT_EN: zero-fill sweep after reset release, reported on busy.
module ramsdp_pipe #(
  parameter int DW     = 32,
  parameter int AW     = 6,
  parameter int BW     = 8,
  parameter int RDLAT  = 1,
  parameter int WFIRST = 0,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [DW/BW-1:0]  wmask_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [DW-1:0]     din_a,
  output logic [DW-1:0]     dout_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic [AW-1:0]     addr_b,
  output logic [DW-1:0]     dout_b,
  output logic              vld_b,
  output logic              busy
);

  localparam int NB    = DW / BW;
  localparam int DEPTH = 1 << AW;

  if ((DW % BW) != 0) begin : g_chk_dw
    $error("ramsdp_pipe: DW (%0d) must be a multiple of BW (%0d)", DW, BW);
  end
  if ((RDLAT != 1) && (RDLAT != 2)) begin : g_chk_lat
    $error("ramsdp_pipe: RDLAT (%0d) must be 1 or 2", RDLAT);
  end

  logic [DW-1:0] mem_q [DEPTH];

  logic          busy_int;
  logic          init_wr;
  logic [AW-1:0] init_addr;

`ifdef RAMSDP_INIT_EN
  logic          busy_q, busy_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    busy_d     = busy_q;
    init_cnt_d = init_cnt_q;
    if (busy_q) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == {AW{1'b1}}) busy_d = 1'b0;
    end
  end

  // Reset parks the sweep at address 0 so every release restarts it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q     <= 1'b1;
      init_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign busy_int  = busy_q;
  assign init_wr   = busy_q;
  assign init_addr = init_cnt_q;
`else
  assign busy_int  = 1'b0;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign busy = busy_int;

  logic          acc_a, acc_b, wr_a;
  logic [DW-1:0] old_a, old_b, merged_a, rd_a, rd_b;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign acc_a = en_a & ~busy_int;
  assign acc_b = en_b & ~busy_int;
  assign wr_a  = acc_a & we_a;

  always_comb begin
    old_a    = mem_q[addr_a];
    old_b    = mem_q[addr_b];
    merged_a = old_a;
    for (int i = 0; i < NB; i++) begin
      if (wmask_a[i]) merged_a[i*BW +: BW] = din_a[i*BW +: BW];
    end
    rd_a = old_a;
    if ((WFIRST != 0) && wr_a) rd_a = merged_a;
    rd_b = old_b;
    if ((BYPASS != 0) && wr_a && (addr_a == addr_b)) rd_b = merged_a;
  end

  always_comb begin
    mem_we    = init_wr | wr_a;
    mem_waddr = init_wr ? init_addr : addr_a;
    mem_wdata = init_wr ? '0 : merged_a;
  end

  // Storage array carries no reset; contents survive nreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic          s_vld_a, s_vld_b;
  logic [DW-1:0] s_dat_a, s_dat_b;

  if (RDLAT == 2) begin : g_lat2
    logic          p_vld_a_q, p_vld_a_d, p_vld_b_q, p_vld_b_d;
    logic [DW-1:0] p_dat_a_q, p_dat_a_d, p_dat_b_q, p_dat_b_d;

    always_comb begin
      p_vld_a_d = acc_a;
      p_vld_b_d = acc_b;
      p_dat_a_d = acc_a ? rd_a : p_dat_a_q;
      p_dat_b_d = acc_b ? rd_b : p_dat_b_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        p_vld_a_q <= 1'b0;
        p_vld_b_q <= 1'b0;
        p_dat_a_q <= '0;
        p_dat_b_q <= '0;
      end else begin
        p_vld_a_q <= p_vld_a_d;
        p_vld_b_q <= p_vld_b_d;
        p_dat_a_q <= p_dat_a_d;
        p_dat_b_q <= p_dat_b_d;
      end
    end

    assign s_vld_a = p_vld_a_q;
    assign s_vld_b = p_vld_b_q;
    assign s_dat_a = p_dat_a_q;
    assign s_dat_b = p_dat_b_q;
  end else begin : g_lat1
    assign s_vld_a = acc_a;
    assign s_vld_b = acc_b;
    assign s_dat_a = rd_a;
    assign s_dat_b = rd_b;
  end

  logic          vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic [DW-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;

  // Outputs only move on a valid result and hold otherwise.
  always_comb begin
    vld_a_d  = s_vld_a;
    vld_b_d  = s_vld_b;
    dout_a_d = s_vld_a ? s_dat_a : dout_a_q;
    dout_b_d = s_vld_b ? s_dat_b : dout_b_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign vld_a  = vld_a_q;
  assign vld_b  = vld_b_q;
  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: tb/tb_ramsdp_pipe.sv
// Scoreboard bench: two instances (default config, and RDLAT=2/write-first/bypass) share one stimulus stream.
module tb_ramsdp_pipe;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          nreset;
  logic          en_a, we_a, en_b;
  logic [3:0]    wmask_a;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a;
  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic          vld_a0, vld_b0, vld_a1, vld_b1, busy0, busy1;

  always #5 clk = ~clk;

  ramsdp_pipe u_dut0 (
    .clk(clk), .nreset(nreset), .en_a(en_a), .we_a(we_a), .wmask_a(wmask_a),
    .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .vld_a(vld_a0),
    .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b0), .vld_b(vld_b0), .busy(busy0)
  );

  ramsdp_pipe #(.RDLAT(2), .WFIRST(1), .BYPASS(1)) u_dut1 (
    .clk(clk), .nreset(nreset), .en_a(en_a), .we_a(we_a), .wmask_a(wmask_a),
    .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b1), .vld_b(vld_b1), .busy(busy1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          care;
    int            due;
  } exp_t;

  exp_t          q [4][$];
  logic [DW-1:0] last [4];
  logic          last_known [4];
  logic [DW-1:0] dout_s [4];
  logic          vld_s [4];
  string         pname [4] = '{"dut0_a", "dut0_b", "dut1_a", "dut1_b"};

  assign dout_s[0] = dout_a0;
  assign dout_s[1] = dout_b0;
  assign dout_s[2] = dout_a1;
  assign dout_s[3] = dout_b1;
  assign vld_s[0]  = vld_a0;
  assign vld_s[1]  = vld_b0;
  assign vld_s[2]  = vld_a1;
  assign vld_s[3]  = vld_b1;

  logic [DW-1:0] mdl [DEPTH];
  logic          known [DEPTH];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: each port's valid/data compared against the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        logic exp_vld;
        exp_t e;
        exp_vld = (q[p].size() > 0) && (q[p][0].due == cyc);
        total++;
        if (vld_s[p] !== exp_vld) begin
          bad++;
          $display("FAIL vld_%s cyc=%0d got=%b want=%b", pname[p], cyc, vld_s[p], exp_vld);
        end
        if (exp_vld) begin
          e = q[p].pop_front();
          if (e.care) begin
            total++;
            if (dout_s[p] !== e.data) begin
              bad++;
              $display("FAIL data_%s cyc=%0d got=%h want=%h", pname[p], cyc, dout_s[p], e.data);
            end
          end
          last[p]       = e.data;
          last_known[p] = e.care;
        end else if (last_known[p]) begin
          total++;
          if (dout_s[p] !== last[p]) begin
            bad++;
            $display("FAIL hold_%s cyc=%0d got=%h want=%h", pname[p], cyc, dout_s[p], last[p]);
          end
        end
      end
`ifndef RAMSDP_INIT_EN
      total++;
      if ((busy0 | busy1) !== 1'b0) begin
        bad++;
        $display("FAIL busy_tie cyc=%0d got=%b%b want=00", cyc, busy0, busy1);
      end
`endif
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                         input logic [3:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // One access cycle; called at posedge+1, the access lands on the next edge.
  task automatic access(input logic ea, input logic wa, input logic [3:0] m, input logic [AW-1:0] aa,
                        input logic [DW-1:0] d, input logic eb, input logic [AW-1:0] ab);
    logic [DW-1:0] olda, oldb, mrg;
    logic          kna, knb, full;
    en_a = ea; we_a = wa; wmask_a = m; addr_a = aa; din_a = d; en_b = eb; addr_b = ab;
    olda = mdl[aa];  kna = known[aa];
    oldb = mdl[ab];  knb = known[ab];
    full = (m == 4'hF);
    mrg  = merge(olda, d, m);
    if (ea) begin
      q[0].push_back('{olda, kna, cyc + 1});
      if (wa) q[2].push_back('{mrg, kna | full, cyc + 2});
      else    q[2].push_back('{olda, kna, cyc + 2});
    end
    if (eb) begin
      q[1].push_back('{oldb, knb, cyc + 1});
      if (ea && wa && (ab == aa)) q[3].push_back('{mrg, kna | full, cyc + 2});
      else                        q[3].push_back('{oldb, knb, cyc + 2});
    end
    if (ea && wa) begin
      mdl[aa]   = mrg;
      known[aa] = kna | full;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic after_release();
`ifdef RAMSDP_INIT_EN
    int n;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b1; end
    n = 0;
    en_a = 1'b1; we_a = 1'b1; wmask_a = 4'hF; din_a = 32'hFFFF_FFFF; en_b = 1'b1;
    while (n < DEPTH + 8) begin
      @(negedge clk);
      if (!(busy0 && busy1)) break;
      n++;
      addr_a = AW'($urandom); addr_b = AW'($urandom);
    end
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0;
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL busy_len got=%0d want=%0d", n, DEPTH);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    nreset = 1'b0;
    en_a = 1'b0; we_a = 1'b0; wmask_a = 4'h0; addr_a = '0; din_a = '0; en_b = 1'b0; addr_b = '0;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    for (int p = 0; p < 4; p++) begin last[p] = '0; last_known[p] = 1'b1; end
    #6;
    for (int p = 0; p < 4; p++) begin
      total++;
      if (vld_s[p] !== 1'b0 || dout_s[p] !== '0) begin
        bad++;
        $display("FAIL reset_%s got=%b/%h want=0/0", pname[p], vld_s[p], dout_s[p]);
      end
    end
    @(posedge clk); #1;
    nreset = 1'b1;
    mon_en = 1'b1;
    after_release();

    // Fill every word so later reads have defined contents.
    for (int a = 0; a < DEPTH; a++) access(1'b1, 1'b1, 4'hF, AW'(a), $urandom, 1'b0, '0);

    access(1'b1, 1'b1, 4'hF, 6'd5, 32'hDEAD_BEEF, 1'b0, '0);
    access(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 6'd5);
    access(1'b1, 1'b1, 4'hF, 6'd3, 32'h1122_3344, 1'b0, '0);
    access(1'b1, 1'b1, 4'b0101, 6'd3, 32'hAABB_CCDD, 1'b0, '0);
    access(1'b1, 1'b0, 4'h0, 6'd3, '0, 1'b1, 6'd3);
    access(1'b1, 1'b1, 4'hF, 6'd7, 32'h0, 1'b0, '0);
    access(1'b1, 1'b1, 4'hF, 6'd7, 32'h1234_5678, 1'b1, 6'd7);
    access(1'b1, 1'b1, 4'h0, 6'd9, 32'hFFFF_FFFF, 1'b1, 6'd9);
    access(1'b0, 1'b1, 4'hF, 6'd9, 32'h5555_5555, 1'b1, 6'd9);
    for (int a = 0; a < 4; a++) access(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(a));
    idle(4);

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] aa, ab;
      aa = AW'($urandom_range(0, 7));
      ab = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, 7));
      access($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), aa, $urandom,
             $urandom_range(0, 3) != 0, ab);
    end

    // Asynchronous reset with reads in flight.
    access(1'b1, 1'b0, 4'h0, 6'd5, '0, 1'b1, 6'd3);
    access(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 6'd5);
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0;
    mon_en = 1'b0;
    #2 nreset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      total++;
      if (vld_s[p] !== 1'b0 || dout_s[p] !== '0) begin
        bad++;
        $display("FAIL midreset_%s got=%b/%h want=0/0", pname[p], vld_s[p], dout_s[p]);
      end
      q[p].delete();
      last[p] = '0;
      last_known[p] = 1'b1;
    end
    @(posedge clk); #1;
    nreset = 1'b1;
    mon_en = 1'b1;
    after_release();
    for (int a = 0; a < 8; a++) access(1'b1, 1'b0, 4'h0, AW'(a), '0, 1'b1, AW'(7 - a));
    for (int i = 0; i < 100; i++)
      access(1'b1, $urandom_range(0, 1) == 1, 4'($urandom), AW'($urandom), $urandom,
             1'b1, AW'($urandom));
    idle(5);

    mon_en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      total++;
      if (q[p].size() != 0) begin
        bad++;
        $display("FAIL drain_%s got=%0d want=0 pending", pname[p], q[p].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
